// File: rtl/video_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_pkg                                                                |
// | Shared video timing defaults, framebuffer geometry and colour types.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package video_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_FB_WIDTH  = 160;
    localparam int DEF_FB_HEIGHT = 240;

    localparam int IDX_W  = 7;
    localparam int RGB_W  = 24;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/tia_palette.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tia_palette                                                              |
// | Combinational NTSC TIA palette ROM: 7-bit colour index to 24-bit RGB.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tia_palette
    import video_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output rgb_t             rgb
);

    // One row per hue, luminance 0 in the leftmost (most significant) slot.
    logic [7:0][RGB_W-1:0] w_row;

    always_comb begin
        w_row = '0;
        unique case (idx[6:3])
            4'h0: w_row = {24'h000000, 24'h404040, 24'h6C6C6C, 24'h909090, 24'hB0B0B0, 24'hC8C8C8, 24'hDCDCDC, 24'hECECEC};
            4'h1: w_row = {24'h444400, 24'h646410, 24'h848424, 24'hA0A034, 24'hB8B840, 24'hD0D050, 24'hE8E85C, 24'hFCFC68};
            4'h2: w_row = {24'h702800, 24'h844414, 24'h985C28, 24'hAC783C, 24'hBC8C4C, 24'hCCA05C, 24'hDCB468, 24'hECC878};
            4'h3: w_row = {24'h841800, 24'h983418, 24'hAC5030, 24'hC06848, 24'hD0805C, 24'hE09470, 24'hECA880, 24'hFCBC94};
            4'h4: w_row = {24'h880000, 24'h9C2020, 24'hB03C3C, 24'hC05858, 24'hD07070, 24'hE08888, 24'hECA0A0, 24'hFCB4B4};
            4'h5: w_row = {24'h78005C, 24'h8C2074, 24'hA03C88, 24'hB0589C, 24'hC070B0, 24'hD084C0, 24'hDC9CD0, 24'hECB0E0};
            4'h6: w_row = {24'h480078, 24'h602090, 24'h783CA4, 24'h8C58B8, 24'hA070CC, 24'hB484DC, 24'hC49CEC, 24'hD4B0FC};
            4'h7: w_row = {24'h140084, 24'h302098, 24'h4C3CAC, 24'h6858C0, 24'h7C70D0, 24'h9488E0, 24'hA8A0EC, 24'hBCB4FC};
            4'h8: w_row = {24'h000088, 24'h1C209C, 24'h3840B0, 24'h505CC0, 24'h6874D0, 24'h7C8CE0, 24'h90A4EC, 24'hA4B8FC};
            4'h9: w_row = {24'h00187C, 24'h1C3890, 24'h3854A8, 24'h5070BC, 24'h6888CC, 24'h7C9CDC, 24'h90B4EC, 24'hA4C8FC};
            4'hA: w_row = {24'h002C5C, 24'h1C4C78, 24'h386890, 24'h5084AC, 24'h689CC0, 24'h7CB4D4, 24'h90CCE8, 24'hA4E0FC};
            4'hB: w_row = {24'h003C2C, 24'h1C5C48, 24'h387C64, 24'h509C80, 24'h68B494, 24'h7CD0AC, 24'h90E4C0, 24'hA4FCD4};
            4'hC: w_row = {24'h003C00, 24'h205C20, 24'h407C40, 24'h5C9C5C, 24'h74B474, 24'h8CD08C, 24'hA4E4A4, 24'hB8FCB8};
            4'hD: w_row = {24'h143800, 24'h345C1C, 24'h507C38, 24'h6C9850, 24'h84B468, 24'h9CCC7C, 24'hB4E490, 24'hC8FCA4};
            4'hE: w_row = {24'h2C3000, 24'h4C501C, 24'h687034, 24'h848C4C, 24'h9CA864, 24'hB4C078, 24'hCCD488, 24'hE0EC9C};
            4'hF: w_row = {24'h442800, 24'h644818, 24'h846830, 24'hA08444, 24'hB89C58, 24'hD0B46C, 24'hE8CC7C, 24'hFCE08C};
        endcase
    end

    assign rgb = w_row[~idx[2:0]];

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_scanout                                                               |
// | VGA-class scanout of the 160x240 TIA framebuffer with 4x/2x replication.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fb_scanout
    import video_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int FB_WIDTH  = DEF_FB_WIDTH,
    parameter int FB_HEIGHT = DEF_FB_HEIGHT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    output logic              fb_rd_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    input  logic [IDX_W-1:0]  fb_dat_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic              frame_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int CNT_W   = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0]  r_h_cnt;
    logic [CNT_W-1:0]  r_v_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_vis1, r_hs1, r_vs1;
    logic              r_vis2, r_hs2, r_vs2;

    logic              w_visible;
    logic              w_hs;
    logic              w_vs;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;
    rgb_t              w_rgb;

    assign w_visible = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hs      = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    assign w_vs      = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));

    // Each framebuffer pixel covers 4 output columns and 2 output lines.
    assign w_row = ADDR_W'(r_v_cnt >> 1);
    assign w_col = ADDR_W'(r_h_cnt >> 2);

    generate
        if (FB_WIDTH == 160 && FB_WIDTH * FB_HEIGHT <= 65536) begin : g_addr_shift
            assign w_addr = (w_row << 7) + (w_row << 5) + w_col;
        end else begin : g_addr_mul
            assign w_addr = ADDR_W'(w_row * ADDR_W'(FB_WIDTH)) + w_col;
        end
    endgenerate

    tia_palette u_palette (
        .idx (r_idx),
        .rgb (w_rgb)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_idx     <= '0;
            r_vis1    <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_vis2    <= 1'b0;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            fb_rd_o   <= 1'b0;
            fb_addr_o <= '0;
            red_o     <= '0;
            green_o   <= '0;
            blue_o    <= '0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            de_o      <= 1'b0;
            frame_o   <= 1'b0;
        end else begin
            fb_rd_o <= 1'b0;
            frame_o <= 1'b0;
            if (enable_i) begin
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    if (r_v_cnt == V_LAST) begin
                        r_v_cnt <= '0;
                        frame_o <= 1'b1;
                    end else begin
                        r_v_cnt <= r_v_cnt + 1'b1;
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end

                // Read stage
                fb_rd_o <= w_visible;
                if (w_visible) begin
                    fb_addr_o <= w_addr;
                end
                r_vis1 <= w_visible;
                r_hs1  <= w_hs;
                r_vs1  <= w_vs;

                // Index stage: read data has settled since the previous enable
                r_idx  <= r_vis1 ? fb_dat_i : '0;
                r_vis2 <= r_vis1;
                r_hs2  <= r_hs1;
                r_vs2  <= r_vs1;

                // Output stage
                red_o   <= r_vis2 ? w_rgb.r : 8'h00;
                green_o <= r_vis2 ? w_rgb.g : 8'h00;
                blue_o  <= r_vis2 ? w_rgb.b : 8'h00;
                hsync_o <= r_hs2;
                vsync_o <= r_vs2;
                de_o    <= r_vis2;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fb_scanout.md
# fb_scanout

Display-side reader for the 160x240 framebuffer that the TIA fills through its pixel write port (7-bit colour index, 16-bit linear address `row*160 + col`). Generates 640x480 VGA-class timing and reads each framebuffer pixel with 4x horizontal and 2x vertical replication. Converts each 7-bit NTSC colour index to 24-bit RGB through a palette ROM. Its RGB/sync/DE outputs feed the HDMI/DVI encoder.

## Interface
Parameters:
- `H_VISIBLE` 640, `H_FRONT` 16, `H_SYNC` 96, `H_BACK` 48: horizontal timing in pixels (line = 800).
- `V_VISIBLE` 480, `V_FRONT` 10, `V_SYNC` 2, `V_BACK` 33: vertical timing in lines (frame = 525).
- `FB_WIDTH` 160, `FB_HEIGHT` 240: framebuffer geometry.

Ports:
- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `enable_i` in 1: pixel enable; one pixel advance per asserted clock; never asserted on two consecutive clocks.
- `fb_rd_o` out 1: framebuffer read strobe, one-clock pulse.
- `fb_addr_o` out 16: framebuffer read address.
- `fb_dat_i` in 7: read data; valid from one clock after `fb_rd_o` and stable until the next `fb_rd_o`.
- `red_o`, `green_o`, `blue_o` out 8 each: pixel colour.
- `hsync_o`, `vsync_o` out 1: sync, active-low.
- `de_o` out 1: display enable (visible area).
- `frame_o` out 1: one-clock pulse when the counters wrap to (0,0).

## Operation
- Counters: `h_cnt` 0..799 and `v_cnt` 0..524 advance only on `enable_i`.
  - `h_cnt` wraps 799->0 and increments `v_cnt`.
  - `v_cnt` wraps 524->0.
- Visible region: `h_cnt` < 640 and `v_cnt` < 480.
- Sync windows:
  - hsync low for `h_cnt` 656..751.
  - vsync low for `v_cnt` 490..491.
- Read stage, on each enable with counters at (h,v):
  - `fb_rd_o` <= visible for one clock.
  - `fb_addr_o` <= `(v>>1)*160 + (h>>2)`, computed as shift-add (`(r<<7)+(r<<5)+c`).
  - Max address 38399; no wrap.
  - Outside the visible region `fb_addr_o` holds its previous value.
- Index stage, at the next enable: `idx_q` <= `fb_dat_i` if the previous read stage was visible, else 0.
- Output stage, at the next enable:
  - RGB <= palette(`idx_q`) when the delayed visible flag is set, else 0.
  - `hsync_o`, `vsync_o`, `de_o` <= their values delayed through two matched stages.
- Palette: standard NTSC TIA palette, 128 entries indexed by COLUxx[7:1]. Greys:
  - idx0 = 000000, idx1 = 404040, idx2 = 6C6C6C, idx3 = 909090
  - idx4 = B0B0B0, idx5 = C8C8C8, idx6 = DCDCDC, idx7 = ECECEC
- `frame_o` asserts for exactly one clock, on the clock after the enable that wraps the counters to (0,0).
- `enable_i` low: all state holds, except that `fb_rd_o` returns to 0.

## Timing
- Reset values, all applied on the first edge with `rst_ni`=0:
  - counters 0, `idx_q` 0, pipeline flags 0.
  - `fb_rd_o` 0, `fb_addr_o` 0.
  - RGB 0, `hsync_o` 1, `vsync_o` 1, `de_o` 0, `frame_o` 0.
- Reset asserted mid-frame aborts the frame. Timing restarts at (0,0) on the first enable after release; no partial pixels are emitted.
- Latency: outputs for position (h,v) appear after the second enable following the enable at which counters equal (h,v). Sync, DE and RGB are always mutually aligned.
- The two-clock minimum enable spacing guarantees `fb_dat_i` is settled at the index-stage enable. This latency is independent of the enable spacing.
- Within each horizontal group of 4 pixels, `fb_rd_o` fires 4 times with the same address. This is legal; the memory must tolerate repeated reads.

## Structure
- `video_pkg` holds: the timing defaults, `FB_WIDTH`/`FB_HEIGHT`, the colour-index width (7), and the RGB struct/width (24).
- Sub-module `tia_palette`: combinational 128-entry case ROM, 7-bit index in, 24-bit RGB out. The TIA diagnostics path can reuse it.
- Counters, address generation and the delay pipeline live in `fb_scanout` itself.

## Test plan
- Reset: hold `rst_ni`=0 for 5 clocks with `enable_i` toggling -> RGB 0, `hsync_o`/`vsync_o` 1, `de_o` 0, `fb_rd_o` 0, `fb_addr_o` 0.
- Line/frame timing with enable every 2 clocks:
  - `de_o` high 640 of every 800 enables.
  - `hsync_o` low 96 enables, starting 656 enables after `de_o` rises.
  - 525 lines per frame; `vsync_o` low for lines 490-491.
  - `frame_o` pulses once per 420000 enables.
- Addressing: at counters (h=4, v=2) -> `fb_addr_o`=161; at (639, 479) -> 38399; `fb_rd_o` never high outside the visible region.
- Replication/palette: memory model returns idx 7 at address 161 and idx 0 elsewhere -> ECECEC on output pixels x=4..7 of lines 2-3, 000000 elsewhere, aligned with `de_o`.
- Enable spacing: rerun one frame with enable every 3 clocks and with irregular 2-5 clock gaps -> output pixel/sync sequence identical per enable to the 2-clock run.
- Mid-frame reset: assert `rst_ni`=0 for 1 clock at (300, 200) -> outputs return to reset values; the next frame starts at (0,0) with `frame_o` pulse timing as in a clean start.
